// File: rtl/systolic_output_requant.sv
// systolic_output_requant: drains output-buffer rows and requantizes each 32-bit lane to saturated int8.
module systolic_output_requant #(
  parameter int DATAWIDTH        = 8,
  parameter int DATAWIDTH_output = 32,
  parameter int N_SIZE           = 32,
  parameter int ADDR_WIDTH       = 10,
  parameter int SCALE_WIDTH      = 16,
  parameter int SHIFT_WIDTH      = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              num_rows,
  input  logic [SCALE_WIDTH-1:0]             scale,
  input  logic [SHIFT_WIDTH-1:0]             shift,
  output logic [ADDR_WIDTH-1:0]              rd_addr_outbuffer,
  input  logic [DATAWIDTH_output*N_SIZE-1:0] rd_data_outbuffer,
  output logic [DATAWIDTH*N_SIZE-1:0]        out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               done
);
  localparam int PW = DATAWIDTH_output + SCALE_WIDTH;
  localparam logic signed [PW:0] QMAX = (PW+1)'((2 ** (DATAWIDTH-1)) - 1);
  localparam logic signed [PW:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0]       num_rows_q, issue_cnt, acc_cnt, addr_q;
  logic [SCALE_WIDTH-1:0]      scale_q;
  logic [SHIFT_WIDTH-1:0]      shift_q;
  logic                        inflight, wr_ptr, rd_ptr, pop, issue;
  logic [1:0]                  fifo_count;
  logic [DATAWIDTH*N_SIZE-1:0] fifo_mem [2];
  logic [DATAWIDTH*N_SIZE-1:0] row_req;

  assign pop = (fifo_count != 2'd0) & out_ready;
  // Credit check: entries held plus the row landing next cycle, net of this cycle's pop.
  assign issue = (state == S_RUN) && (issue_cnt < num_rows_q) &&
                 ({1'b0, fifo_count} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
  assign rd_addr_outbuffer = issue ? issue_cnt : addr_q;
  assign out_valid = fifo_count != 2'd0;
  assign out_data = fifo_mem[rd_ptr];
  assign busy = state == S_RUN;
  assign done = state == S_DONE;

  for (genvar i = 0; i < N_SIZE; i++) begin : g_lane
    logic signed [PW-1:0] p;
    logic signed [PW:0]   pe, rnd, sh_r, r;
    always_comb begin
      p    = PW'($signed(rd_data_outbuffer[i*DATAWIDTH_output +: DATAWIDTH_output])) *
             PW'($signed({1'b0, scale_q}));
      pe   = (PW+1)'(p);
      rnd  = pe + $signed((PW+1)'(1) << (shift_q - SHIFT_WIDTH'(1)));
      sh_r = rnd >>> shift_q;
      r    = (shift_q == '0) ? pe : (32'(shift_q) >= PW) ? {(PW+1){pe[PW]}} : sh_r;
    end
    assign row_req[i*DATAWIDTH +: DATAWIDTH] = (r > QMAX) ? QMAX[DATAWIDTH-1:0] :
                                               (r < QMIN) ? QMIN[DATAWIDTH-1:0] : r[DATAWIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      num_rows_q  <= '0;
      scale_q     <= '0;
      shift_q     <= '0;
      issue_cnt   <= '0;
      acc_cnt     <= '0;
      addr_q      <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          num_rows_q <= num_rows;
          scale_q    <= scale;
          shift_q    <= shift;
          issue_cnt  <= '0;
          acc_cnt    <= '0;
          state      <= (num_rows == '0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (issue) issue_cnt <= issue_cnt + ADDR_WIDTH'(1);
          if (pop) acc_cnt <= acc_cnt + ADDR_WIDTH'(1);
          if (pop && acc_cnt == num_rows_q - ADDR_WIDTH'(1)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
      inflight <= issue;
      if (issue) addr_q <= issue_cnt;
      if (inflight) begin
        fifo_mem[wr_ptr] <= row_req;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + 2'(inflight) - 2'(pop);
    end
  end
endmodule

// File: doc/systolic_output_requant.md
# systolic_output_requant

Drains final-result tiles from the systolic output buffer and requantizes each row of `N_SIZE` 32-bit accumulators to signed 8-bit. Rows are delivered on a valid/ready stream to the next stage (activation or writeback). It sits directly downstream of the systolic top: it drives that block's output-buffer read address and consumes its read data. It uses a credit-limited 2-entry FIFO, so throughput is one row per cycle under full backpressure tolerance.

## Interface
- `DATAWIDTH`, 8: output element width (signed).
- `DATAWIDTH_output`, 32: accumulator element width (signed).
- `N_SIZE`, 32: elements per row.
- `ADDR_WIDTH`, 10: output-buffer address width.
- `SCALE_WIDTH`, 16: unsigned multiplier width.
- `SHIFT_WIDTH`, 6: right-shift amount width.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin drain; sampled only in IDLE.
- `num_rows`  in  ADDR_WIDTH  rows to drain, from address 0; latched on accepted `start`.
- `scale`  in  SCALE_WIDTH  multiplier; latched on accepted `start`.
- `shift`  in  SHIFT_WIDTH  arithmetic right shift; latched on accepted `start`.
- `rd_addr_outbuffer`  out  ADDR_WIDTH  output-buffer read address.
- `rd_data_outbuffer`  in  DATAWIDTH_output*N_SIZE  buffer data; valid the cycle after the address is presented.
- `out_data`  out  DATAWIDTH*N_SIZE  requantized row; element i at `[i*DATAWIDTH +: DATAWIDTH]`.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last row is accepted.

## Operation
States:
- IDLE: `start`=1 latches the inputs, clears the counters and goes to RUN. If `num_rows`=0 it goes directly to DONE instead.
- RUN: issues reads and accepts rows. Moves to DONE on the cycle the `num_rows`-th row handshakes.
- DONE: asserts `done` for one cycle, then returns to IDLE.

Counters:
- `issue_cnt` counts reads issued.
- `acc_cnt` counts rows handshaked.
- `rd_addr_outbuffer` = `issue_cnt` when a read is issued; it holds its value otherwise.

Issue rule:
- A read is issued in RUN when `issue_cnt < num_rows` and `fifo_count + inflight - pop < 2`.
- `inflight` is 1 if a read was issued the previous cycle.
- `pop` = `out_valid & out_ready`.

Arrival:
- On the cycle after an issue, all `N_SIZE` lanes are requantized combinationally and pushed into the FIFO at the clock edge.

FIFO:
- Depth 2; `out_data` is the FIFO head and `out_valid` = FIFO non-empty.
- Push and pop in the same cycle are both honoured.
- The credit rule guarantees the FIFO never overflows.

Requantization, per lane:
- p = acc (signed 32) × scale (zero-extended unsigned), 48-bit signed.
- If shift>0: r = (p + 2^(shift−1)) >>> shift, i.e. round half toward +∞. If shift=0: r = p.
- Saturate r to [−128, 127].
- A shift of 48 or more yields 0 for p≥0 and −1 for p<0 before saturation.

Other rules:
- `start` in RUN or DONE is ignored.
- `out_valid`/`out_data` hold stable until handshaked; the block never retracts valid.
- Reset mid-operation: asserting `rst_n`=0 aborts immediately and discards the FIFO and in-flight data. After reset the block is in IDLE, and the buffer contents are untouched.

## Timing
- Reset values: `rd_addr_outbuffer`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0. FIFO empty, state IDLE.
- `start` sampled at cycle S:
  - S+1: RUN, `busy`=1, address 0 presented.
  - S+2: row 0 data arrives and is pushed.
  - S+3: `out_valid`=1.
- With `out_ready` held at 1: one row per cycle, last row valid at S+2+`num_rows`.
- `done`=1 on the cycle after the final handshake, with `busy`=0 in the same cycle. The block is back in IDLE, able to accept `start`, one cycle later.
- `num_rows`=0: `done` at S+1, no reads issued, `out_valid` never asserted.
- Backpressure: while `out_ready`=0, at most 2 rows are buffered and `issue_cnt` stalls. On release, throughput returns to 1/cycle with no bubble.

## Test plan
- `num_rows`=4, scale=1, shift=0, rows hold lane values 100, 300, −300, 0, `out_ready`=1 -> lanes 100, 127, −128, 0; rows at S+3..S+6; `done` at S+7.
- scale=1, shift=1, acc=5 / −5 / 3 -> 3 / −2 / 2. scale=3, shift=2, acc=−7 -> −5.
- `num_rows`=8, `out_ready` toggling 1,0,0,1,… -> all 8 rows delivered in address order 0..7; no duplicates or drops; `out_data` stable while stalled.
- `num_rows`=0 -> `done` pulse at S+1; `rd_addr_outbuffer` stays 0; `out_valid` stays 0.
- `start` pulsed during RUN with different `num_rows`/`scale` -> ignored; original drain completes unchanged.
- `rst_n` asserted with 2 rows buffered -> `out_valid`=0 immediately. A new `start` with `num_rows`=2 after reset re-reads from address 0 and gives correct outputs.
